// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC layer sequencer.
package mac_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_ACCUM_WIDTH = 48;
    localparam int DEF_VEC         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_EMIT,
        ST_FIN
    } state_t;

    typedef logic signed [DEF_ACCUM_WIDTH-1:0] accum_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Chunk, neuron and weight address counters for the MAC sequencer.
// The weight address is a free-running count of reads, so it equals j*n_chunks+k without a multiplier.
module mac_addr_gen #(
    parameter int CHUNK_W = 8,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [CHUNK_W-1:0] n_chunks,
    input  logic [CHUNK_W-1:0] n_out,
    input  logic               step,
    input  logic               next_neuron,
    output logic [ADDR_W-1:0]  act_addr,
    output logic [ADDR_W-1:0]  wgt_addr,
    output logic [CHUNK_W-1:0] neuron,
    output logic               first_chunk,
    output logic               last_chunk,
    output logic               last_neuron
);

    logic [CHUNK_W-1:0] n_chunks_q;
    logic [CHUNK_W-1:0] n_out_q;
    logic [CHUNK_W-1:0] chunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_chunks_q <= '0;
            n_out_q    <= '0;
            chunk      <= '0;
            neuron     <= '0;
            wgt_addr   <= '0;
        end else if (load) begin
            n_chunks_q <= n_chunks;
            n_out_q    <= n_out;
            chunk      <= '0;
            neuron     <= '0;
            wgt_addr   <= '0;
        end else begin
            if (step) begin
                wgt_addr <= wgt_addr + 1'b1;
                chunk    <= last_chunk ? '0 : chunk + 1'b1;
            end
            if (next_neuron)
                neuron <= neuron + 1'b1;
        end
    end

    assign first_chunk = (chunk == '0);
    assign last_chunk  = (chunk == n_chunks_q - 1'b1);
    assign last_neuron = (neuron == n_out_q - 1'b1);
    assign act_addr    = ADDR_W'(chunk);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Layer sequencer: streams activation/weight chunk reads into a sibling MAC and emits one sum per neuron.
// Optional bias preload on chunk 0 is enabled by defining MACSEQ_BIAS_EN.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACCUM_WIDTH = DEF_ACCUM_WIDTH,
    parameter int VEC         = DEF_VEC,
    parameter int CHUNK_W     = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CHUNK_W-1:0]     n_chunks,
    input  logic [CHUNK_W-1:0]     n_out,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      act_addr,
    output logic [ADDR_W-1:0]      wgt_addr,
    output logic                   mac_en,
    output logic                   mac_acc_en,
    output logic [ACCUM_WIDTH-1:0] mac_acc_in,
    input  logic [ACCUM_WIDTH-1:0] mac_c,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACCUM_WIDTH-1:0] res_data,
    output logic [CHUNK_W-1:0]     res_idx
`ifdef MACSEQ_BIAS_EN
    ,
    output logic [ADDR_W-1:0]      bias_addr,
    input  logic [DATA_WIDTH-1:0]  bias_data
`endif
);

    // A full VEC-lane dot product must fit in the accumulator.
    if (ACCUM_WIDTH < 2 * DATA_WIDTH + $clog2(VEC)) begin : g_width_chk
        $error("mac_seq_ctrl: ACCUM_WIDTH too narrow for DATA_WIDTH and VEC");
    end

    state_t                        state;
    logic signed [ACCUM_WIDTH-1:0] acc;
    logic                          first_chunk;
    logic                          last_chunk;
    logic                          last_neuron;
    logic                          load;
    logic                          next_neuron;

    assign load        = (state == ST_IDLE) && start;
    assign next_neuron = (state == ST_EMIT) && res_ready;

    mac_addr_gen #(
        .CHUNK_W(CHUNK_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .n_chunks   (n_chunks),
        .n_out      (n_out),
        .step       (rd_en),
        .next_neuron(next_neuron),
        .act_addr   (act_addr),
        .wgt_addr   (wgt_addr),
        .neuron     (res_idx),
        .first_chunk(first_chunk),
        .last_chunk (last_chunk),
        .last_neuron(last_neuron)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            mac_en     <= 1'b0;
            mac_acc_en <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            mac_en <= rd_en;
`ifdef MACSEQ_BIAS_EN
            mac_acc_en <= rd_en;
`else
            mac_acc_en <= rd_en && !first_chunk;
`endif
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (n_chunks != '0 && n_out != '0) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            rd_en <= 1'b1;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_chunk) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_EMIT;
                    res_valid <= 1'b1;
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (last_neuron) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            rd_en <= 1'b1;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (mac_en)
            acc <= $signed(mac_c);
    end

    assign res_data = acc;

`ifdef MACSEQ_BIAS_EN
    logic bias_first;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bias_first <= 1'b0;
        else
            bias_first <= rd_en && first_chunk;
    end

    assign bias_addr  = ADDR_W'(res_idx);
    assign mac_acc_in = bias_first
                      ? {{(ACCUM_WIDTH-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data}
                      : acc;
`else
    assign mac_acc_in = acc;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural RAM + MAC model and a result scoreboard.
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    localparam int DW  = 16;
    localparam int ACW = 48;
    localparam int VL  = 16;
    localparam int CW  = 8;
    localparam int AW  = 8;
    localparam int MEM = 256;

    logic           clk;
    logic           rst;
    logic           start;
    logic [CW-1:0]  n_chunks;
    logic [CW-1:0]  n_out;
    logic           busy;
    logic           done;
    logic           rd_en;
    logic [AW-1:0]  act_addr;
    logic [AW-1:0]  wgt_addr;
    logic           mac_en;
    logic           mac_acc_en;
    logic [ACW-1:0] mac_acc_in;
    logic [ACW-1:0] mac_c;
    logic           res_valid;
    logic           res_ready;
    logic [ACW-1:0] res_data;
    logic [CW-1:0]  res_idx;
    int             bias_val;
`ifdef MACSEQ_BIAS_EN
    localparam bit BIAS = 1'b1;
    logic [AW-1:0]  bias_addr;
    logic [DW-1:0]  bias_data;
`else
    localparam bit BIAS = 1'b0;
`endif

    mac_seq_ctrl #(
        .DATA_WIDTH (DW),
        .ACCUM_WIDTH(ACW),
        .VEC        (VL),
        .CHUNK_W    (CW),
        .ADDR_W     (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_chunks  (n_chunks),
        .n_out     (n_out),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .act_addr  (act_addr),
        .wgt_addr  (wgt_addr),
        .mac_en    (mac_en),
        .mac_acc_en(mac_acc_en),
        .mac_acc_in(mac_acc_in),
        .mac_c     (mac_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx)
`ifdef MACSEQ_BIAS_EN
        ,
        .bias_addr (bias_addr),
        .bias_data (bias_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one cycle read latency and a combinational MAC sibling
    logic signed [DW-1:0] act_mem [MEM][VL];
    logic signed [DW-1:0] wgt_mem [MEM][VL];
    logic signed [DW-1:0] act_q [VL];
    logic signed [DW-1:0] wgt_q [VL];
    longint               mac_sum;

    always @(posedge clk) begin
        if (rd_en) begin
            for (int l = 0; l < VL; l++) begin
                act_q[l] <= act_mem[act_addr][l];
                wgt_q[l] <= wgt_mem[wgt_addr][l];
            end
        end
    end

`ifdef MACSEQ_BIAS_EN
    always @(posedge clk) bias_data <= DW'(bias_val);
`endif

    always_comb begin
        mac_sum = mac_acc_en ? longint'($signed(mac_acc_in)) : 64'sd0;
        for (int l = 0; l < VL; l++)
            mac_sum = mac_sum + longint'(act_q[l]) * longint'(wgt_q[l]);
    end
    assign mac_c = mac_sum[ACW-1:0];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        longint data;
        int     idx;
    } res_t;
    res_t sb[$];

    task automatic fill(input int mode, input int a, input int b);
        for (int ad = 0; ad < MEM; ad++)
            for (int l = 0; l < VL; l++) begin
                if (mode == 0) begin
                    act_mem[ad][l] = DW'(a);
                    wgt_mem[ad][l] = DW'(b);
                end else begin
                    act_mem[ad][l] = DW'((ad * 3 + l) % 11 - 5);
                    wgt_mem[ad][l] = DW'((ad * 7 + l * 5) % 13 - 6);
                end
            end
    endtask

    function automatic longint model(input int nc, input int j);
        longint s;
        s = BIAS ? longint'(bias_val) : 0;
        for (int k = 0; k < nc; k++)
            for (int l = 0; l < VL; l++)
                s += longint'(act_mem[k][l]) * longint'(wgt_mem[(j * nc + k) % MEM][l]);
        return s;
    endfunction

    task automatic run_layer(input int nc, input int no, input int stall, input bit mid_start);
        int     cyc, exp_k, exp_w, prev_k, cur_k, first_valid, nvalid, nrd, done_cyc, stalled, jn, exp_done;
        bit     prev_rd, active;
        longint hold_d;
        int     hold_i;
        res_t   e;
        active   = (nc != 0) && (no != 0);
        exp_done = active ? no * (nc + 2 + stall) + 1 : 1;
        if (active)
            for (int j = 0; j < no; j++) sb.push_back('{model(nc, j), j});
        @(negedge clk);
        n_chunks  = CW'(nc);
        n_out     = CW'(no);
        start     = 1'b1;
        res_ready = (stall == 0);
        cyc = 0; exp_k = 0; exp_w = 0; prev_k = -1; prev_rd = 1'b0;
        first_valid = -1; nvalid = 0; nrd = 0; done_cyc = -1; stalled = 0; jn = 0;
        hold_d = 0; hold_i = 0;
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = mid_start && (cyc == 3);
            if (start) begin
                n_chunks = 1;
                n_out    = 1;
            end
            if (cyc == 1) chk("busy_start", busy, active);
            chk("mac_en", mac_en, prev_rd);
            chk("mac_acc_en", mac_acc_en, BIAS ? prev_rd : (prev_rd && prev_k != 0));
            cur_k = -1;
            if (rd_en) begin
                chk("act_addr", act_addr, exp_k);
                chk("wgt_addr", wgt_addr, exp_w);
`ifdef MACSEQ_BIAS_EN
                if (exp_k == 0) chk("bias_addr", bias_addr, jn);
`endif
                nrd++;
                cur_k = exp_k;
                exp_w = (exp_w + 1) % MEM;
                exp_k = (exp_k == nc - 1) ? 0 : exp_k + 1;
            end
            prev_rd = rd_en;
            prev_k  = cur_k;
            if (res_valid) begin
                chk("rd_in_emit", rd_en, 0);
                if (first_valid < 0) first_valid = cyc;
                if (stalled < stall) begin
                    res_ready = 1'b0;
                    if (stalled == 0) begin
                        hold_d = $signed(res_data);
                        hold_i = res_idx;
                    end else begin
                        chk("stall_data", $signed(res_data), hold_d);
                        chk("stall_idx", res_idx, hold_i);
                    end
                    stalled++;
                end else begin
                    if (stall > 0) chk("stall_data_end", $signed(res_data), hold_d);
                    res_ready = 1'b1;
                    if (sb.size() == 0) chk("sb_empty", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("res_data", $signed(res_data), e.data);
                        chk("res_idx", res_idx, e.idx);
                    end
                    stalled = 0;
                    nvalid++;
                    jn++;
                end
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
        end
        start = 1'b0;
        if (done_cyc < 0) chk("timeout", 1, 0);
        else chk("done_cycle", done_cyc, exp_done);
        if (active) chk("latency", first_valid, nc + 2);
        chk("read_count", nrd, active ? nc * no : 0);
        chk("result_count", nvalid, active ? no : 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        res_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_chunks = '0; n_out = '0; res_ready = 1'b1; bias_val = 0;
        fill(0, 1, 1);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", $signed(res_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // all-ones lanes, two neurons, spurious start mid-run
        run_layer(3, 2, 0, 1'b1);

        fill(0, -2, 3);
        run_layer(2, 1, 0, 1'b0);

        fill(1, 0, 0);
        run_layer(2, 2, 4, 1'b0);

        run_layer(3, 0, 0, 1'b0);
        run_layer(0, 2, 0, 1'b0);

        // reset while reading chunk 1
        sb.delete();
        @(negedge clk);
        n_chunks = 4; n_out = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_chunk", act_addr, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_act_addr", act_addr, 0);
        chk("arst_wgt_addr", wgt_addr, 0);
        chk("arst_mac_en", mac_en, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_mac_acc_in", $signed(mac_acc_in), 0);
        @(negedge clk);
        chk("arst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 0);
        run_layer(1, 3, 0, 1'b0);

        // weight address wraps past 2^AW
        run_layer(20, 14, 0, 1'b0);

`ifdef MACSEQ_BIAS_EN
        bias_val = 5;
        fill(0, 1, 1);
        run_layer(1, 1, 0, 1'b0);
        bias_val = -7;
        fill(1, 0, 0);
        run_layer(3, 2, 0, 1'b0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
